// File: rtl/missile_ctl.sv
// Player missile launcher/mover; source of xpos_missile/ypos_missile/on_missile for the enemy collision detectors.
// Latency: a launch is visible one cycle after the fire request; moves and retirements one cycle after frame_tick/hit.
// Backpressure: none; fire requests outside IDLE are dropped. Optional macro MISSILE_AUTOFIRE_EN: level-triggered fire.
module missile_ctl #(
    parameter int SPEED           = 8,
    parameter int LAUNCH_OFFSET   = 10,
    parameter int Y_TOP           = 0,
    parameter int COOLDOWN_FRAMES = 12
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        fire,
    input  logic        frame_tick,
    input  logic [11:0] xpos_player,
    input  logic [11:0] ypos_player,
    input  logic        hit,
    output logic [11:0] xpos_missile,
    output logic [11:0] ypos_missile,
    output logic        on_missile,
    output logic        ready,
    output logic [7:0]  shot_cnt
);

    localparam int CNT_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    localparam logic [11:0]      SPEED_W   = 12'(SPEED);
    localparam logic [11:0]      LAUNCH_W  = 12'(LAUNCH_OFFSET);
    localparam logic [11:0]      Y_TOP_W   = 12'(Y_TOP);
    // Below this player y the spawn point would sit above the top edge.
    localparam logic [11:0]      SPAWN_MIN = 12'(Y_TOP + LAUNCH_OFFSET);
    // Below this missile y one more step would cross the top edge.
    localparam logic [11:0]      STEP_MIN  = 12'(Y_TOP + SPEED);
    localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLIGHT   = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    state_t           state_q;
    logic             fire_q;
    logic [CNT_W-1:0] cool_q;
    logic [11:0]      xpos_q;
    logic [11:0]      ypos_q;
    logic             on_q;
    logic             ready_q;
    logic [7:0]       shot_q;

    logic             launch_d;
    logic [11:0]      spawn_y_d;

`ifdef MISSILE_AUTOFIRE_EN
    // Holding fire is enough; a launch happens whenever the block is idle.
    assign launch_d = fire;
`else
    // Only a fresh press launches; a held button never re-triggers.
    assign launch_d = fire & ~fire_q;
`endif

    // Spawn point above the player, clamped so it never starts past the top edge.
    assign spawn_y_d = (ypos_player < SPAWN_MIN) ? Y_TOP_W : (ypos_player - LAUNCH_W);

    // Launch/flight/cooldown state machine with all outputs registered.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fire_q  <= 1'b0;
            cool_q  <= '0;
            xpos_q  <= 12'd0;
            ypos_q  <= 12'd0;
            on_q    <= 1'b0;
            ready_q <= 1'b1;
            shot_q  <= 8'd0;
        end else begin
            fire_q <= fire;
            case (state_q)
                IDLE: begin
                    // hit is meaningless without a missile in the air.
                    if (launch_d) begin
                        xpos_q  <= xpos_player;
                        ypos_q  <= spawn_y_d;
                        on_q    <= 1'b1;
                        ready_q <= 1'b0;
                        shot_q  <= shot_q + 8'd1;
                        state_q <= FLIGHT;
                    end
                end
                FLIGHT: begin
                    // A hit wins over a same-cycle frame tick; the top-edge check keeps y from wrapping.
                    if (hit || (frame_tick && (ypos_q < STEP_MIN))) begin
                        on_q <= 1'b0;
                        if (COOLDOWN_FRAMES == 0) begin
                            ready_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            cool_q  <= COOL_LOAD;
                            state_q <= COOLDOWN;
                        end
                    end else if (frame_tick) begin
                        ypos_q <= ypos_q - SPEED_W;
                    end
                end
                COOLDOWN: begin
                    // Positions hold; consumers gate them with on_missile.
                    if (frame_tick) begin
                        if (cool_q == CNT_ONE) begin
                            ready_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            cool_q <= cool_q - CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    on_q    <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign xpos_missile = xpos_q;
    assign ypos_missile = ypos_q;
    assign on_missile   = on_q;
    assign ready        = ready_q;
    assign shot_cnt     = shot_q;

endmodule

// File: tb/tb_missile_ctl.sv
// Self-checking bench for missile_ctl: launch, flight, top exit, clamp, hit priority, reset, held fire.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
// Launch expectations go through a scoreboard queue; held-fire expectations follow MISSILE_AUTOFIRE_EN.
module tb_missile_ctl;

    logic        pclk = 1'b0;
    logic        rst_n;
    logic        fire;
    logic        frame_tick;
    logic [11:0] xpos_player;
    logic [11:0] ypos_player;
    logic        hit;
    logic [11:0] xpos_missile;
    logic [11:0] ypos_missile;
    logic        on_missile;
    logic        ready;
    logic [7:0]  shot_cnt;

    typedef struct {
        logic [11:0] x;
        logic [11:0] y;
        logic [7:0]  shot;
    } launch_t;

    launch_t    sb_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_shot = 8'd0;

    missile_ctl dut (
        .pclk         (pclk),
        .rst_n        (rst_n),
        .fire         (fire),
        .frame_tick   (frame_tick),
        .xpos_player  (xpos_player),
        .ypos_player  (ypos_player),
        .hit          (hit),
        .xpos_missile (xpos_missile),
        .ypos_missile (ypos_missile),
        .on_missile   (on_missile),
        .ready        (ready),
        .shot_cnt     (shot_cnt)
    );

    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
    endtask

    // Drives a fire request and records the launch the DUT should produce.
    task automatic drive_launch(input logic [11:0] x, input logic [11:0] y);
        launch_t e;
        xpos_player = x;
        ypos_player = y;
        fire        = 1'b1;
        e.x         = x;
        e.y         = (y < 12'd10) ? 12'd0 : (y - 12'd10);
        exp_shot    = exp_shot + 8'd1;
        e.shot      = exp_shot;
        sb_q.push_back(e);
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fire = 1'b0; frame_tick = 1'b0; hit = 1'b0;
        xpos_player = 12'd0; ypos_player = 12'd0;
        repeat (3) tick();
        exp_shot = 8'd0;
        n_checks++;
        if (xpos_missile !== 12'd0 || ypos_missile !== 12'd0 || on_missile !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pos: x=%0d y=%0d on=%0b, want 0 0 0", xpos_missile, ypos_missile, on_missile);
        end
        n_checks++;
        if (ready !== 1'b1 || shot_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_ctl: ready=%0b shot=%0d, want 1 0", ready, shot_cnt);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (ready !== 1'b1 || on_missile !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: ready=%0b on=%0b, want 1 0", ready, on_missile);
        end
    endtask

    task automatic test_launch();
        launch_t e;
        drive_launch(12'd320, 12'd500);
        fire = 1'b0;
        e = sb_q.pop_front();
        n_checks++;
        if (on_missile !== 1'b1 || xpos_missile !== e.x || ypos_missile !== e.y || shot_cnt !== e.shot) begin
            n_fail++;
            $display("FAIL launch: x=%0d y=%0d on=%0b shot=%0d, want x=%0d y=%0d on=1 shot=%0d",
                     xpos_missile, ypos_missile, on_missile, shot_cnt, e.x, e.y, e.shot);
        end
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL launch_ready: ready=%0b, want 0", ready);
        end
    endtask

    task automatic test_flight();
        logic [11:0] ym;
        ym = 12'd490;
        for (int i = 0; i < 5; i++) begin
            frame();
            ym = ym - 12'd8;
            n_checks++;
            if (ypos_missile !== ym || on_missile !== 1'b1) begin
                n_fail++;
                $display("FAIL flight_step%0d: y=%0d on=%0b, want y=%0d on=1", i, ypos_missile, on_missile, ym);
            end
            fire = 1'b1; tick();
            fire = 1'b0; tick();
        end
        n_checks++;
        if (ypos_missile !== 12'd450 || xpos_missile !== 12'd320 || shot_cnt !== exp_shot) begin
            n_fail++;
            $display("FAIL flight_end: y=%0d x=%0d shot=%0d, want 450 320 %0d", ypos_missile, xpos_missile, shot_cnt, exp_shot);
        end
        hit = 1'b1; tick(); hit = 1'b0;
        n_checks++;
        if (on_missile !== 1'b0 || ypos_missile !== 12'd450 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flight_hit: on=%0b y=%0d ready=%0b, want 0 450 0", on_missile, ypos_missile, ready);
        end
        repeat (11) frame();
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flight_cool11: ready=%0b, want 0", ready);
        end
        frame();
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flight_cool12: ready=%0b, want 1", ready);
        end
    endtask

    task automatic test_top_exit();
        launch_t e;
        drive_launch(12'd100, 12'd30);
        fire = 1'b0;
        e = sb_q.pop_front();
        n_checks++;
        if (on_missile !== 1'b1 || xpos_missile !== e.x || ypos_missile !== e.y || shot_cnt !== e.shot) begin
            n_fail++;
            $display("FAIL top_launch: x=%0d y=%0d on=%0b shot=%0d, want x=%0d y=%0d on=1 shot=%0d",
                     xpos_missile, ypos_missile, on_missile, shot_cnt, e.x, e.y, e.shot);
        end
        frame();
        n_checks++;
        if (ypos_missile !== 12'd12) begin
            n_fail++;
            $display("FAIL top_y12: y=%0d, want 12", ypos_missile);
        end
        frame();
        n_checks++;
        if (ypos_missile !== 12'd4) begin
            n_fail++;
            $display("FAIL top_y4: y=%0d, want 4", ypos_missile);
        end
        frame();
        n_checks++;
        if (on_missile !== 1'b0 || ypos_missile !== 12'd4 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL top_retire: on=%0b y=%0d ready=%0b, want 0 4 0", on_missile, ypos_missile, ready);
        end
        repeat (11) frame();
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL top_cool11: ready=%0b, want 0", ready);
        end
        frame();
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL top_cool12: ready=%0b, want 1", ready);
        end
    endtask

    task automatic test_clamp();
        launch_t e;
        drive_launch(12'd50, 12'd5);
        fire = 1'b0;
        e = sb_q.pop_front();
        n_checks++;
        if (on_missile !== 1'b1 || xpos_missile !== e.x || ypos_missile !== e.y || shot_cnt !== e.shot) begin
            n_fail++;
            $display("FAIL clamp_launch: x=%0d y=%0d on=%0b shot=%0d, want x=%0d y=%0d on=1 shot=%0d",
                     xpos_missile, ypos_missile, on_missile, shot_cnt, e.x, e.y, e.shot);
        end
        frame();
        n_checks++;
        if (on_missile !== 1'b0 || ypos_missile !== 12'd0) begin
            n_fail++;
            $display("FAIL clamp_retire: on=%0b y=%0d, want 0 0", on_missile, ypos_missile);
        end
        repeat (12) frame();
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL clamp_cool: ready=%0b, want 1", ready);
        end
    endtask

    task automatic test_hit_priority();
        launch_t e;
        drive_launch(12'd200, 12'd210);
        fire = 1'b0;
        e = sb_q.pop_front();
        n_checks++;
        if (on_missile !== 1'b1 || ypos_missile !== e.y || shot_cnt !== e.shot) begin
            n_fail++;
            $display("FAIL hp_launch: y=%0d on=%0b shot=%0d, want y=%0d on=1 shot=%0d",
                     ypos_missile, on_missile, shot_cnt, e.y, e.shot);
        end
        hit = 1'b1; frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        n_checks++;
        if (on_missile !== 1'b0 || ypos_missile !== 12'd200 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hp_retire: on=%0b y=%0d ready=%0b, want 0 200 0", on_missile, ypos_missile, ready);
        end
        tick();
        hit = 1'b0;
        fire = 1'b1; tick();
        fire = 1'b0; tick();
        n_checks++;
        if (on_missile !== 1'b0 || shot_cnt !== exp_shot || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hp_cool_fire: on=%0b shot=%0d ready=%0b, want 0 %0d 0", on_missile, shot_cnt, ready, exp_shot);
        end
        repeat (11) frame();
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hp_cool11: ready=%0b, want 0", ready);
        end
        frame();
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hp_cool12: ready=%0b, want 1", ready);
        end
    endtask

    task automatic test_reset_midflight();
        launch_t e;
        drive_launch(12'd64, 12'd310);
        fire = 1'b0;
        e = sb_q.pop_front();
        n_checks++;
        if (on_missile !== 1'b1 || ypos_missile !== e.y) begin
            n_fail++;
            $display("FAIL rmf_launch: y=%0d on=%0b, want y=%0d on=1", ypos_missile, on_missile, e.y);
        end
        rst_n = 1'b0;
        tick();
        exp_shot = 8'd0;
        n_checks++;
        if (on_missile !== 1'b0 || ypos_missile !== 12'd0 || xpos_missile !== 12'd0 ||
            ready !== 1'b1 || shot_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL rmf_reset: on=%0b y=%0d x=%0d ready=%0b shot=%0d, want 0 0 0 1 0",
                     on_missile, ypos_missile, xpos_missile, ready, shot_cnt);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_held_fire();
        launch_t e;
        drive_launch(12'd320, 12'd500);
        e = sb_q.pop_front();
        n_checks++;
        if (on_missile !== 1'b1 || shot_cnt !== e.shot || ypos_missile !== e.y) begin
            n_fail++;
            $display("FAIL held_launch: on=%0b y=%0d shot=%0d, want 1 %0d %0d", on_missile, ypos_missile, shot_cnt, e.y, e.shot);
        end
        repeat (3) tick();
        hit = 1'b1; tick(); hit = 1'b0;
        repeat (11) frame();
        n_checks++;
        if (on_missile !== 1'b0 || ready !== 1'b0 || shot_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL held_cooldown: on=%0b ready=%0b shot=%0d, want 0 0 1", on_missile, ready, shot_cnt);
        end
        frame();
        n_checks++;
        if (ready !== 1'b1 || on_missile !== 1'b0) begin
            n_fail++;
            $display("FAIL held_ready: ready=%0b on=%0b, want 1 0", ready, on_missile);
        end
`ifdef MISSILE_AUTOFIRE_EN
        exp_shot = exp_shot + 8'd1;
        e.x = 12'd320; e.y = 12'd490; e.shot = exp_shot;
        sb_q.push_back(e);
        tick();
        e = sb_q.pop_front();
        n_checks++;
        if (on_missile !== 1'b1 || shot_cnt !== e.shot || ypos_missile !== e.y || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL autofire_relaunch: on=%0b shot=%0d y=%0d ready=%0b, want 1 %0d %0d 0",
                     on_missile, shot_cnt, ypos_missile, ready, e.shot, e.y);
        end
        fire = 1'b0;
        tick();
`else
        tick();
        n_checks++;
        if (on_missile !== 1'b0 || shot_cnt !== 8'd1 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL held_no_relaunch: on=%0b shot=%0d ready=%0b, want 0 1 1", on_missile, shot_cnt, ready);
        end
        fire = 1'b0;
        tick();
        drive_launch(12'd320, 12'd500);
        fire = 1'b0;
        e = sb_q.pop_front();
        n_checks++;
        if (on_missile !== 1'b1 || shot_cnt !== e.shot || ypos_missile !== e.y) begin
            n_fail++;
            $display("FAIL held_repress: on=%0b shot=%0d y=%0d, want 1 %0d %0d", on_missile, shot_cnt, ypos_missile, e.shot, e.y);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_launch();
        test_flight();
        test_top_exit();
        test_clamp();
        test_hit_priority();
        test_reset_midflight();
        test_held_fire();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
